// File: rtl/logic_gate_vector_checker_if.sv
// Interface bundling the checker's run control, its stimulus to the gate
// block, the gate outputs it observes and its result flags.
// master: the checker itself. slave: whoever requests runs and hosts the gate.
interface logic_gate_vector_checker_if #(
    parameter int ERR_W = 3
);
    logic             start;
    logic [6:0]       gate_out;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [6:0]       mismatch_mask;
    logic [1:0]       fail_vec;
    logic [6:0]       fail_bits;

    modport master (
        input  start, gate_out,
        output a, b, busy, done, pass, err_count, mismatch_mask, fail_vec, fail_bits
    );

    modport slave (
        output start, gate_out,
        input  a, b, busy, done, pass, err_count, mismatch_mask, fail_vec, fail_bits
    );
endinterface

// File: rtl/logic_gate_vector_checker.sv
// Walks a two-input gate block through the four a/b combinations, waits
// SETTLE_CYCLES per vector, then compares the seven gate outputs against
// the truth table and accumulates an error count and a sticky mismatch mask.
// Optional first-failure capture (fail_vec/fail_bits) is enabled by defining
// GATE_CHK_FIRST_FAIL_EN; otherwise both are tied to zero.
module logic_gate_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    logic_gate_vector_checker_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t           state;
    state_t           state_next;
    logic             start_run;
    logic [1:0]       vec;
    logic [1:0]       vec_next;
    logic [3:0]       settle_cnt;
    logic             a_q;
    logic             b_q;
    logic [ERR_W-1:0] err_count;
    logic [6:0]       mismatch_mask;
    logic [6:0]       expected;
    logic [6:0]       diff;

    assign vec_next = vec + 2'd1;

    // Truth table for the current vector, bit order {xnor,xor,nota,nor,nand,or,and}
    always_comb begin
        expected = {~(vec[1] ^ vec[0]), vec[1] ^ vec[0], ~vec[1],
                    ~(vec[1] | vec[0]), ~(vec[1] & vec[0]),
                    vec[1] | vec[0], vec[1] & vec[0]};
        diff     = bus.gate_out ^ expected;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured when no run is in flight
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = SETTLE;
                    start_run  = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd1) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                state_next = (vec == 2'd3) ? DONE : SETTLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Vector sequencing, settle timing and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            vec           <= 2'd0;
            settle_cnt    <= 4'd0;
            a_q           <= 1'b0;
            b_q           <= 1'b0;
            err_count     <= '0;
            mismatch_mask <= 7'd0;
        end else if (start_run) begin
            vec           <= 2'd0;
            settle_cnt    <= SETTLE_LOAD;
            a_q           <= 1'b0;
            b_q           <= 1'b0;
            err_count     <= '0;
            mismatch_mask <= 7'd0;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt - 4'd1;
        end else if (state == SAMPLE) begin
            mismatch_mask <= mismatch_mask | diff;
            if (diff != 7'd0) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (vec != 2'd3) begin
                vec        <= vec_next;
                a_q        <= vec_next[1];
                b_q        <= vec_next[0];
                settle_cnt <= SETTLE_LOAD;
            end
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [1:0] fail_vec_q;
    logic [6:0] fail_bits_q;

    // Capture the first failing vector of a run; a nonzero fail_bits marks it taken
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            fail_vec_q  <= 2'd0;
            fail_bits_q <= 7'd0;
        end else if (state == SAMPLE && diff != 7'd0 && fail_bits_q == 7'd0) begin
            fail_vec_q  <= vec;
            fail_bits_q <= diff;
        end
    end

    assign bus.fail_vec  = fail_vec_q;
    assign bus.fail_bits = fail_bits_q;
`else
    assign bus.fail_vec  = 2'd0;
    assign bus.fail_bits = 7'd0;
`endif

    assign bus.a             = a_q;
    assign bus.b             = b_q;
    assign bus.busy          = (state == SETTLE) || (state == SAMPLE);
    assign bus.done          = (state == DONE);
    assign bus.pass          = (state == DONE) && (err_count == '0);
    assign bus.err_count     = err_count;
    assign bus.mismatch_mask = mismatch_mask;

endmodule
